// File: rtl/msrv32_wr_en_pkg.sv
// Shared definitions for the msrv32 writeback write-enable controller:
// FSM encoding, channel indices and a width helper for the shadow counter.
package msrv32_wr_en_pkg;

    localparam logic RUN    = 1'b0;
    localparam logic SHADOW = 1'b1;

    localparam int CH_RF  = 0;
    localparam int CH_CSR = 1;

    typedef enum logic {
        ST_RUN    = RUN,
        ST_SHADOW = SHADOW
    } wr_en_state_e;

    // A zero-length shadow still needs a 1-bit counter so the register stays legal.
    function automatic int shadow_cnt_width(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/msrv32_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment
// and the count sticks at all-ones instead of wrapping.
module msrv32_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear first, then saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/msrv32_wr_en_ctrl.sv
// Writeback write-enable controller: gates per-channel write requests against
// flush/stall, suppresses them for a refill shadow after a flush, and counts writes/kills.
module msrv32_wr_en_ctrl
    import msrv32_wr_en_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int ADDR_W        = 12,
    parameter int SHADOW_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic                       ms_riscv32_mp_clk_in,
    input  logic                       ms_riscv32_mp_rst_n_in,
    input  logic                       flush_in,
    input  logic                       stall_in,
    input  logic [NUM_CH-1:0]          wr_en_req_in,
    input  logic [NUM_CH*ADDR_W-1:0]   wr_addr_in,
    input  logic                       cnt_clr_in,
    output logic [NUM_CH-1:0]          wr_en_out,
    output logic [NUM_CH*ADDR_W-1:0]   wr_addr_out,
    output logic                       shadow_active_out,
    output logic [NUM_CH*CNT_W-1:0]    wr_cnt_out,
    output logic [CNT_W-1:0]           kill_cnt_out
);

    localparam int             SH_W    = shadow_cnt_width(SHADOW_CYCLES);
    localparam logic [SH_W-1:0] SH_ZERO = {SH_W{1'b0}};
    localparam logic [SH_W-1:0] SH_ONE  = SH_W'(1);
    localparam logic [SH_W-1:0] SH_LOAD = SH_W'(SHADOW_CYCLES);
    localparam bit             SHADOW_EN = (SHADOW_CYCLES > 0);

    logic                      clk;
    logic                      rst_n;
    wr_en_state_e              state_r;
    logic [SH_W-1:0]           sh_cnt_r;
    logic                      shadow_active_r;
    logic [NUM_CH-1:0]         wr_en_r;
    logic [NUM_CH*ADDR_W-1:0]  wr_addr_r;
    logic                      pass_s;
    logic [NUM_CH-1:0]         issue_s;
    logic                      kill_inc_s;
    logic [NUM_CH:0]           cnt_inc_s;
    logic [(NUM_CH+1)*CNT_W-1:0] cnt_all_s;

    assign clk   = ms_riscv32_mp_clk_in;
    assign rst_n = ms_riscv32_mp_rst_n_in;

    // Issue gating and kill detection for the current cycle.
    always_comb begin
        pass_s     = ~flush_in & ~stall_in & (state_r == ST_RUN);
        issue_s    = wr_en_req_in & {NUM_CH{pass_s}};
        kill_inc_s = (|wr_en_req_in) & (flush_in | (state_r == ST_SHADOW));
        cnt_inc_s  = {kill_inc_s, issue_s};
    end

    // RUN/SHADOW FSM; flush (re)arms the shadow and outranks both stall and decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_RUN;
            sh_cnt_r        <= SH_ZERO;
            shadow_active_r <= 1'b0;
        end else if (flush_in && SHADOW_EN) begin
            state_r         <= ST_SHADOW;
            sh_cnt_r        <= SH_LOAD;
            shadow_active_r <= 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    state_r         <= ST_RUN;
                    sh_cnt_r        <= sh_cnt_r;
                    shadow_active_r <= 1'b0;
                end
                ST_SHADOW: begin
                    if (stall_in) begin
                        state_r         <= ST_SHADOW;
                        sh_cnt_r        <= sh_cnt_r;
                        shadow_active_r <= 1'b1;
                    end else if (sh_cnt_r == SH_ONE) begin
                        state_r         <= ST_RUN;
                        sh_cnt_r        <= SH_ZERO;
                        shadow_active_r <= 1'b0;
                    end else begin
                        state_r         <= ST_SHADOW;
                        sh_cnt_r        <= sh_cnt_r - SH_ONE;
                        shadow_active_r <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= ST_RUN;
                    sh_cnt_r        <= SH_ZERO;
                    shadow_active_r <= 1'b0;
                end
            endcase
        end
    end

    // Write-enable register: one-cycle latency, requests are never held over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r <= {NUM_CH{1'b0}};
        end else begin
            wr_en_r <= issue_s;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_addr
            // Address slice loads only on issue so it stays stable between writes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_addr_r[g*ADDR_W +: ADDR_W] <= {ADDR_W{1'b0}};
                end else if (issue_s[g]) begin
                    wr_addr_r[g*ADDR_W +: ADDR_W] <= wr_addr_in[g*ADDR_W +: ADDR_W];
                end else begin
                    wr_addr_r[g*ADDR_W +: ADDR_W] <= wr_addr_r[g*ADDR_W +: ADDR_W];
                end
            end
        end

        // Counters 0..NUM_CH-1 track issued writes; the last one tracks killed cycles.
        for (g = 0; g <= NUM_CH; g++) begin : g_cnt
            msrv32_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (cnt_clr_in),
                .inc   (cnt_inc_s[g]),
                .cnt   (cnt_all_s[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign wr_en_out         = wr_en_r;
    assign wr_addr_out       = wr_addr_r;
    assign shadow_active_out = shadow_active_r;
    assign wr_cnt_out        = cnt_all_s[NUM_CH*CNT_W-1:0];
    assign kill_cnt_out      = cnt_all_s[NUM_CH*CNT_W +: CNT_W];

endmodule
